// File: rtl/fir_job_sequencer.sv
// FIR job sequencer: streams coefficients and samples from the memory s2 port, MACs them
// and writes saturated 32-bit results back into the same memory. One job runs per start pulse.
module fir_job_sequencer #(
    parameter int ADDR_W = 15,
    parameter int ACC_W  = 48
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] coef_base,
    input  logic [ADDR_W-1:0] samp_base,
    input  logic [ADDR_W-1:0] res_base,
    input  logic [8:0]        num_taps,
    input  logic [ADDR_W-1:0] num_out,
    input  logic [4:0]        shift,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    typedef enum logic [2:0] {IDLE, RD_C, RD_X, FLUSH, WR, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] coef_base_r, samp_base_r, res_base_r, nout_r;
    logic [8:0]        taps_r;
    logic [4:0]        shift_r;
    logic [8:0]        i_r;
    logic [ADDR_W-1:0] k_r;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0] coef_r;
    logic               err_r;

    logic               last_tap, last_out;
    logic signed [15:0] samp;
    logic signed [31:0] prod;
    logic signed [ACC_W-1:0] prod_ext, acc_sh;
    logic [31:0]        sat;
    logic               fits;

    assign last_tap = (i_r == taps_r - 9'd1);
    assign last_out = (k_r == nout_r - ONE_A);
    assign samp     = mem_readdata[15:0];
    assign prod     = coef_r * samp;
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

    // Saturate: the shifted value fits in 32 bits only if bits [ACC_W-1:31] are all equal.
    assign acc_sh = acc >>> shift_r;
    assign fits   = (&acc_sh[ACC_W-1:31]) | ~(|acc_sh[ACC_W-1:31]);
    always_comb begin
        sat = acc_sh[31:0];
        if (!fits) sat = acc_sh[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_taps == 9'd0 || num_out == ZERO_A) state_nxt = ERR;
                    else                                       state_nxt = RD_C;
                end
            end
            RD_C:    state_nxt = RD_X;
            RD_X:    state_nxt = last_tap ? FLUSH : RD_C;
            FLUSH:   state_nxt = WR;
            WR:      state_nxt = last_out ? DONE : RD_C;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Memory-side outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        case (state)
            RD_C: begin
                mem_chipselect = 1'b1;
                mem_address    = coef_base_r + ADDR_W'(i_r);
            end
            RD_X: begin
                mem_chipselect = 1'b1;
                mem_address    = samp_base_r + k_r + ADDR_W'(i_r);
            end
            WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = res_base_r + k_r;
                mem_writedata  = sat;
            end
            default: ;
        endcase
    end

    assign mem_byteenable = {4{mem_chipselect}};
    assign busy           = (state != IDLE) && (state != DONE);
    assign mem_clken      = busy;
    assign done           = (state == DONE);
    assign err            = err_r;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= IDLE;
            coef_base_r <= '0;
            samp_base_r <= '0;
            res_base_r  <= '0;
            nout_r      <= '0;
            taps_r      <= '0;
            shift_r     <= '0;
            i_r         <= '0;
            k_r         <= '0;
            acc         <= '0;
            coef_r      <= '0;
            err_r       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            coef_base_r <= coef_base;
                            samp_base_r <= samp_base;
                            res_base_r  <= res_base;
                            nout_r      <= num_out;
                            taps_r      <= num_taps;
                            shift_r     <= shift;
                            err_r       <= 1'b0;
                            acc         <= '0;
                            i_r         <= '0;
                            k_r         <= '0;
                        end
                    end
                    // x[k+i-1] arrives while c[i] is being addressed; pair it with the held c[i-1].
                    RD_C: if (i_r != 9'd0) acc <= acc + prod_ext;
                    RD_X: begin
                        coef_r <= samp;
                        if (!last_tap) i_r <= i_r + 9'd1;
                    end
                    FLUSH: acc <= acc + prod_ext;
                    WR: begin
                        if (!last_out) begin
                            k_r <= k_r + ONE_A;
                            i_r <= '0;
                            acc <= '0;
                        end
                    end
                    ERR: err_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Directed bench for fir_job_sequencer with a 1-cycle-latency word memory model.
module tb_fir_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [14:0] coef_base = '0, samp_base = '0, res_base = '0, num_out = '0;
    logic [8:0]  num_taps = '0;
    logic [4:0]  shift = '0;
    logic        busy, done, err;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] rdata = '0;

    int checks = 0;
    int failures = 0;

    fir_job_sequencer dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
        .coef_base(coef_base), .samp_base(samp_base), .res_base(res_base),
        .num_taps(num_taps), .num_out(num_out), .shift(shift),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(rdata)
    );

    always #5 clk = ~clk;

    // Memory model: request captured at negedge, served at posedge.
    logic [31:0] mem [0:32767];
    logic        req_cs = 1'b0, req_wr = 1'b0, req_en = 1'b0;
    logic [14:0] req_a = '0;
    logic [31:0] req_d = '0;
    logic        ld_en = 1'b0;
    logic [14:0] ld_a = '0;
    logic [31:0] ld_d = '0;
    logic [14:0] rd_q[$];
    logic [14:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          cs_cnt = 0;

    always @(negedge clk) begin
        req_cs = mem_chipselect;
        req_wr = mem_write;
        req_en = mem_clken;
        req_a  = mem_address;
        req_d  = mem_writedata;
        if (mem_chipselect) begin
            cs_cnt = cs_cnt + 1;
            if (mem_write) begin
                wa_q.push_back(mem_address);
                wd_q.push_back(mem_writedata);
            end else begin
                rd_q.push_back(mem_address);
            end
        end
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_a] <= ld_d;
        else if (req_cs && req_en) begin
            if (req_wr) mem[req_a] <= req_d;
            else        rdata <= mem[req_a];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [14:0] a, input logic [31:0] d);
        ld_a = a; ld_d = d; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic run_job(input logic [14:0] cb, input logic [14:0] sb, input logic [14:0] rb,
                           input logic [8:0] t, input logic [14:0] n, input logic [4:0] sh,
                           input int abort_at, input int start_at, input int rst_at,
                           output int done_at, output bit busy_ok);
        int cyc;
        rd_q.delete(); wa_q.delete(); wd_q.delete(); cs_cnt = 0;
        @(posedge clk); #1;
        coef_base = cb; samp_base = sb; res_base = rb;
        num_taps = t; num_out = n; shift = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; done_at = 0; busy_ok = 1'b1;
        while (cyc < 2000) begin
            if (done) begin
                done_at = cyc;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy && abort_at == 0 && rst_at == 0) busy_ok = 1'b0;
            if (abort_at != 0 && cyc == abort_at + 1) check("abort_idle_busy", busy, 0);
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == start_at) begin
                start = 1'b1; num_taps = 9'd1; res_base = rb + 15'd100;
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_outs", {busy, done, err, mem_chipselect, mem_clken, mem_write,
                                       mem_byteenable, mem_address, mem_writedata}, 0);
            end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; rst_n = 1'b1;
            if ((abort_at != 0 && cyc > abort_at + 30) || (rst_at != 0 && cyc > rst_at + 30)) break;
            cyc = cyc + 1;
        end
    endtask

    int  d_at;
    bit  b_ok;
    logic [14:0] exp_rd[$];

    task automatic check_t3_result(input string tag);
        check({tag, "_nwr"}, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check({tag, "_a0"}, wa_q[0], 600);
            check({tag, "_d0"}, wd_q[0], 5);
            check({tag, "_a1"}, wa_q[1], 601);
            check({tag, "_d1"}, wd_q[1], 18);
        end
    endtask

    initial begin
        #2;
        check("reset_outs", {busy, done, err, mem_chipselect, mem_clken, mem_write,
                             mem_byteenable, mem_address, mem_writedata}, 0);
        #20;
        rst_n = 1'b1;

        // T=1, N=1, upper bits of memory words carry garbage
        poke(100, 32'hABCD_0002);
        poke(200, 32'h1234_0003);
        run_job(100, 200, 300, 1, 1, 0, 0, 0, 0, d_at, b_ok);
        check("t1_done_cyc", d_at, 5);
        check("t1_busy", b_ok, 1);
        check("t1_nwr", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("t1_waddr", wa_q[0], 300);
            check("t1_wdata", wd_q[0], 32'h6);
        end

        // T=3, N=2 with a stray start and changed inputs mid-job
        poke(400, 1); poke(401, 2); poke(402, 3);
        poke(500, 1); poke(501, 32'h0000_FFFF); poke(502, 2); poke(503, 5);
        run_job(400, 500, 600, 3, 2, 0, 0, 3, 0, d_at, b_ok);
        check("t3_done_cyc", d_at, 17);
        check("t3_busy", b_ok, 1);
        check_t3_result("t3");
        exp_rd.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) begin
                exp_rd.push_back(15'(400 + i));
                exp_rd.push_back(15'(500 + k + i));
            end
        check("t3_nrd", rd_q.size(), 12);
        if (rd_q.size() == 12)
            for (int j = 0; j < 12; j++) check("t3_rdaddr", rd_q[j], exp_rd[j]);

        // T=256 saturation cases
        for (int i = 0; i < 256; i++) begin
            poke(15'(1000 + i), 32'h0000_7FFF);
            poke(15'(2000 + i), 32'h0000_7FFF);
        end
        run_job(1000, 2000, 3000, 256, 1, 0, 0, 0, 0, d_at, b_ok);
        check("t256_done_cyc", d_at, 515);
        check("t256_sat_pos", (wd_q.size() == 1) ? wd_q[0] : 32'hDEAD, 32'h7FFF_FFFF);
        run_job(1000, 2000, 3000, 256, 1, 8, 0, 0, 0, d_at, b_ok);
        check("t256_shift8", (wd_q.size() == 1) ? wd_q[0] : 32'hDEAD, 32'h3FFF_0001);
        for (int i = 0; i < 256; i++) poke(15'(1000 + i), 32'h0000_8000);
        run_job(1000, 2000, 3000, 256, 1, 0, 0, 0, 0, d_at, b_ok);
        check("t256_sat_neg", (wd_q.size() == 1) ? wd_q[0] : 32'hDEAD, 32'h8000_0000);

        // Sample address wrap
        poke(4000, 3); poke(4001, 4); poke(15'h7FFF, 5); poke(0, 6);
        run_job(4000, 15'h7FFF, 4100, 2, 1, 0, 0, 0, 0, d_at, b_ok);
        check("wrap_data", (wd_q.size() == 1) ? wd_q[0] : 32'hDEAD, 39);
        check("wrap_nrd", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            check("wrap_x0", rd_q[1], 15'h7FFF);
            check("wrap_x1", rd_q[3], 15'h0000);
        end

        // Parameter errors, then recovery
        run_job(100, 200, 300, 0, 1, 0, 0, 0, 0, d_at, b_ok);
        check("err_taps_done_cyc", d_at, 2);
        check("err_taps_flag", err, 1);
        check("err_taps_nocs", cs_cnt, 0);
        run_job(100, 200, 300, 1, 0, 0, 0, 0, 0, d_at, b_ok);
        check("err_nout_done_cyc", d_at, 2);
        check("err_nout_flag", err, 1);
        run_job(100, 200, 300, 1, 1, 0, 0, 0, 0, d_at, b_ok);
        check("err_cleared", err, 0);
        check("err_recover_data", (wd_q.size() == 1) ? wd_q[0] : 32'hDEAD, 6);

        // Abort in cycle 6, then a clean rerun
        run_job(400, 500, 600, 3, 2, 0, 6, 0, 0, d_at, b_ok);
        check("abort_no_done", d_at, 0);
        check("abort_no_write", wa_q.size(), 0);
        check("abort_err", err, 0);
        run_job(400, 500, 600, 3, 2, 0, 0, 0, 0, d_at, b_ok);
        check("abort_rerun_cyc", d_at, 17);
        check_t3_result("abort_rerun");

        // Reset mid-job, then a clean rerun
        run_job(400, 500, 600, 3, 2, 0, 0, 0, 4, d_at, b_ok);
        check("rst_no_done", d_at, 0);
        check("rst_no_write", wa_q.size(), 0);
        run_job(400, 500, 600, 3, 2, 0, 0, 0, 0, d_at, b_ok);
        check("rst_rerun_cyc", d_at, 17);
        check_t3_result("rst_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
